hazard_ctrl: RTL and testbench
==============================

HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 SHALL have parameter MUL_LAT, default 3, EX-stage cycles for a multiply op (legal range 2..15).
REQ-002 SHALL have parameter MUL_ALUOP, default 4'b1010, aluop code identifying a multiply.
REQ-003 SHALL have parameter MEM_TIMEOUT, default 255, the number of consecutive memory wait cycles before timeout is flagged.
REQ-004 SHALL have ports: clk input 1, clock; reset input 1, reset, asynchronous, active-high.
REQ-005 SHALL have ports: ID_rs1, ID_rs2 input 5 each, ID-stage source registers; ID_uses_rs1, ID_uses_rs2 input 1 each, source operand used.
REQ-006 SHALL have ports: ID_EX_memread input 1; ID_EX_rd input 5; ID_EX_aluop input 4, from the ID/EX register.
REQ-007 SHALL have port EX_take input 1, taken branch or jump resolved in EX this cycle.
REQ-008 SHALL have ports: EX_MEM_memread, EX_MEM_memwrite input 1 each; mem_ready input 1, data memory handshake ready.
REQ-009 SHALL have outputs, each 1 bit: PC_stall, IF_ID_stall, IF_ID_flush, ID_bubble (ID/EX loads zero controls), EX_stall (hold ID/EX), EX_MEM_bubble, MEM_stall.
REQ-010 SHALL have outputs: mem_timeout 1 (sticky), stall_count 16, flush_count 16 (perf counters).

Function
REQ-011 SHALL implement FSM states RUN, MUL, MEMWAIT; state register and counters clocked on posedge clk.
REQ-012 SHALL define mem_pend = (EX_MEM_memread | EX_MEM_memwrite) & ~mem_ready, evaluated combinationally.
REQ-013 Priority (highest first): mem_pend, MUL busy, branch flush, load-use.
REQ-014 mem_pend=1: PC_stall, IF_ID_stall, EX_stall, MEM_stall = 1; all other outputs 0; enter/remain MEMWAIT; MUL counter frozen.
REQ-015 MEMWAIT exits to the saved return state (RUN or MUL) in the cycle after mem_ready=1; stalls drop combinationally in the cycle mem_ready=1.
REQ-016 Wait counter (8 bits, saturating) increments each mem_pend cycle and clears when mem_pend=0; mem_timeout sets when the count reaches MEM_TIMEOUT and holds until reset.
REQ-017 In RUN, when ID_EX_aluop==MUL_ALUOP and mul_done=0: load the counter with MUL_LAT-1 and enter MUL; EX_stall, IF_ID_stall, PC_stall, EX_MEM_bubble = 1 that cycle.
REQ-018 In MUL: same outputs while counter>0; counter decrements each non-mem_pend cycle; at 0, go to RUN, set mul_done, outputs 0.
REQ-019 A multiply SHALL occupy EX exactly MUL_LAT cycles (MUL_LAT-1 stall cycles) absent memory waits.
REQ-020 mul_done SHALL clear on the first edge with EX_stall=0 after being set, so back-to-back multiplies each stall.
REQ-021 Branch flush: EX_take=1 with no higher-priority condition asserts IF_ID_flush=1 and ID_bubble=1, with PC_stall=0; flush_count increments.
REQ-022 Load-use: ID_EX_memread & ID_EX_rd!=0 & ((rd==ID_rs1 & ID_uses_rs1) | (rd==ID_rs2 & ID_uses_rs2)) asserts PC_stall, IF_ID_stall, ID_bubble for that cycle only.
REQ-023 Flush and load-use together: flush wins, with no PC_stall.
REQ-024 stall_count SHALL increment on every cycle PC_stall=1; both perf counters SHALL wrap at 16'hFFFF.

Reset
REQ-025 Reset SHALL force state RUN, all counters 0, mul_done 0, mem_timeout 0, and all stall/flush/bubble outputs 0 while reset is high.
REQ-026 Reset asserted mid-MUL or mid-MEMWAIT SHALL abandon the operation; the first post-reset cycle is RUN.

Structure
REQ-027 State encoding and the MUL_ALUOP default SHALL reside in the shared pipeline package.
REQ-028 The block SHALL contain one sub-module, hazard_perf_cnt (16-bit wrapping enable counter), instantiated twice.

Verification
REQ-029 ID_EX_memread=1, ID_EX_rd=5, ID_rs2=5, ID_uses_rs2=1 -> PC_stall=IF_ID_stall=ID_bubble=1 for 1 cycle; stall_count=1.
REQ-030 ID_EX_aluop=4'b1010, MUL_LAT=3 -> EX_stall=1 for 2 cycles then 0; a second multiply immediately following -> 2 further stall cycles.
REQ-031 EX_MEM_memread=1, mem_ready low for 4 cycles -> all stalls plus MEM_stall=1 for 4 cycles; released in the cycle mem_ready=1.
REQ-032 EX_take=1 together with a load-use match -> IF_ID_flush=1, ID_bubble=1, PC_stall=0; flush_count=1.
REQ-033 mem_ready held low for 300 cycles -> mem_timeout=1 at cycle 255 and remains high; reset then clears it.
REQ-034 Reset pulse at the second cycle of MUL -> all outputs 0; state RUN; counter 0 after release.

Source files
------------

// File: rtl/hazard_ctrl_pkg.sv
// Shared pipeline definitions for the hazard controller: FSM state encoding,
// the default multiply aluop code, counter widths and a small helper used by
// the load-use detector.
package hazard_ctrl_pkg;

    // Hazard FSM states. MEMWAIT remembers which of RUN/MUL it interrupted.
    typedef enum logic [1:0] {
        ST_RUN     = 2'd0,
        ST_MUL     = 2'd1,
        ST_MEMWAIT = 2'd2
    } hz_state_t;

    // aluop code that identifies a multi-cycle multiply in EX.
    localparam logic [3:0] ALUOP_MUL_DEFAULT = 4'b1010;

    // Width of the multiply latency counter (MUL_LAT tops out at 15).
    localparam int MUL_CNT_W  = 4;

    // Width of the saturating memory wait counter.
    localparam int WAIT_CNT_W = 8;

    // Width of the performance counters.
    localparam int PERF_CNT_W = 16;

    // True when a consumer source register matches a producer destination
    // and the consumer actually reads that operand.
    function automatic logic src_match(
        input logic [4:0] rd,
        input logic [4:0] rs,
        input logic       uses
    );
        return uses && (rd == rs);
    endfunction

endpackage

// File: rtl/hazard_perf_cnt.sv
// Free-running performance counter: counts cycles where en is high and wraps
// back to zero after the all-ones value.
module hazard_perf_cnt #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         en,
    output logic [W-1:0] count
);

    logic [W-1:0] count_reg;
    logic [W-1:0] count_next;

    // Natural modulo-2^W increment gives the wrap for free.
    always_comb begin
        count_next = count_reg;
        if (en) begin
            count_next = count_reg + W'(1);
        end
    end

    // Counter register, cleared asynchronously by reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_reg <= '0;
        end else begin
            count_reg <= count_next;
        end
    end

    assign count = count_reg;

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller for a 5-stage in-order core. Resolves, in
// priority order, data-memory waits, multi-cycle multiplies in EX, taken
// branch flushes and load-use interlocks, and keeps stall/flush perf counts.
module hazard_ctrl
    import hazard_ctrl_pkg::*;
#(
    parameter int          MUL_LAT     = 3,
    parameter logic [3:0]  MUL_ALUOP   = ALUOP_MUL_DEFAULT,
    parameter int unsigned MEM_TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        reset,
    // ID stage operands
    input  logic [4:0]  ID_rs1,
    input  logic [4:0]  ID_rs2,
    input  logic        ID_uses_rs1,
    input  logic        ID_uses_rs2,
    // ID/EX register
    input  logic        ID_EX_memread,
    input  logic [4:0]  ID_EX_rd,
    input  logic [3:0]  ID_EX_aluop,
    // EX branch resolution
    input  logic        EX_take,
    // EX/MEM register and data memory handshake
    input  logic        EX_MEM_memread,
    input  logic        EX_MEM_memwrite,
    input  logic        mem_ready,
    // Pipeline controls
    output logic        PC_stall,
    output logic        IF_ID_stall,
    output logic        IF_ID_flush,
    output logic        ID_bubble,
    output logic        EX_stall,
    output logic        EX_MEM_bubble,
    output logic        MEM_stall,
    // Status and perf counters
    output logic        mem_timeout,
    output logic [15:0] stall_count,
    output logic [15:0] flush_count
);

    // Value loaded when a multiply is first seen: the number of EX cycles it
    // still needs, counting the current one's successor cycles down to a
    // final non-stalling cycle at count 1.
    localparam logic [MUL_CNT_W-1:0] MUL_LOAD = MUL_CNT_W'(MUL_LAT - 1);
    localparam logic [WAIT_CNT_W-1:0] WAIT_MAX = '1;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    hz_state_t              state_reg;
    hz_state_t              state_next;
    hz_state_t              ret_state_reg;
    hz_state_t              ret_state_next;
    logic [MUL_CNT_W-1:0]   mul_cnt_reg;
    logic [MUL_CNT_W-1:0]   mul_cnt_next;
    logic                   mul_done_reg;
    logic                   mul_done_next;
    logic [WAIT_CNT_W-1:0]  wait_cnt_reg;
    logic [WAIT_CNT_W-1:0]  wait_cnt_next;
    logic                   mem_timeout_reg;
    logic                   mem_timeout_next;

    // ------------------------------------------------------------------
    // Hazard detection (all combinational)
    // ------------------------------------------------------------------
    logic      mem_pend;
    hz_state_t eff_state;
    logic      mul_op;
    logic      mul_start;
    logic      mul_stall;
    logic      mul_last;
    logic      mul_busy;
    logic      load_use;

    assign mem_pend = (EX_MEM_memread | EX_MEM_memwrite) & ~mem_ready;

    // The cycle mem_ready arrives, MEMWAIT behaves like the state it
    // interrupted so the released pipeline continues without a dead cycle.
    assign eff_state = (state_reg == ST_MEMWAIT) ? ret_state_reg : state_reg;

    assign mul_op    = (ID_EX_aluop == MUL_ALUOP);
    // mul_done blocks re-triggering on a multiply that has already served
    // its stall cycles but has not yet left ID/EX.
    assign mul_start = (eff_state == ST_RUN) & mul_op & ~mul_done_reg;
    assign mul_stall = (eff_state == ST_MUL) & (mul_cnt_reg > MUL_CNT_W'(1));
    assign mul_last  = (eff_state == ST_MUL) & ~mul_stall;
    assign mul_busy  = mul_start | mul_stall;

    assign load_use = ID_EX_memread & (ID_EX_rd != 5'd0) &
                      (src_match(ID_EX_rd, ID_rs1, ID_uses_rs1) |
                       src_match(ID_EX_rd, ID_rs2, ID_uses_rs2));

    // ------------------------------------------------------------------
    // FSM process 1: state and control registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg       <= ST_RUN;
            ret_state_reg   <= ST_RUN;
            mul_cnt_reg     <= '0;
            mul_done_reg    <= 1'b0;
            wait_cnt_reg    <= '0;
            mem_timeout_reg <= 1'b0;
        end else begin
            state_reg       <= state_next;
            ret_state_reg   <= ret_state_next;
            mul_cnt_reg     <= mul_cnt_next;
            mul_done_reg    <= mul_done_next;
            wait_cnt_reg    <= wait_cnt_next;
            mem_timeout_reg <= mem_timeout_next;
        end
    end

    // ------------------------------------------------------------------
    // FSM process 2: next state, multiply counter and memory wait tracking
    // ------------------------------------------------------------------
    always_comb begin
        state_next     = eff_state;
        ret_state_next = ret_state_reg;
        mul_cnt_next   = mul_cnt_reg;

        if (mem_pend) begin
            // Freeze the multiply counter; remember where to come back to.
            state_next = ST_MEMWAIT;
            if (state_reg != ST_MEMWAIT) begin
                ret_state_next = state_reg;
            end
        end else if (mul_start) begin
            state_next   = ST_MUL;
            mul_cnt_next = MUL_LOAD;
        end else if (mul_stall) begin
            state_next   = ST_MUL;
            mul_cnt_next = mul_cnt_reg - MUL_CNT_W'(1);
        end else if (mul_last) begin
            state_next   = ST_RUN;
            mul_cnt_next = '0;
        end

        // mul_done goes high once the remaining EX time drops to the final
        // cycle and falls on the next edge where EX is allowed to advance.
        mul_done_next = mul_done_reg;
        if (!EX_stall) begin
            mul_done_next = 1'b0;
        end else if (mul_busy && !mem_pend && (mul_cnt_next == MUL_CNT_W'(1))) begin
            mul_done_next = 1'b1;
        end

        // Saturating count of consecutive memory wait cycles.
        if (!mem_pend) begin
            wait_cnt_next = '0;
        end else if (wait_cnt_reg == WAIT_MAX) begin
            wait_cnt_next = WAIT_MAX;
        end else begin
            wait_cnt_next = wait_cnt_reg + WAIT_CNT_W'(1);
        end

        mem_timeout_next = mem_timeout_reg |
                           (mem_pend && (32'(wait_cnt_next) >= 32'(MEM_TIMEOUT)));
    end

    // ------------------------------------------------------------------
    // FSM process 3: prioritised pipeline controls, all low during reset
    // ------------------------------------------------------------------
    always_comb begin
        PC_stall      = 1'b0;
        IF_ID_stall   = 1'b0;
        IF_ID_flush   = 1'b0;
        ID_bubble     = 1'b0;
        EX_stall      = 1'b0;
        EX_MEM_bubble = 1'b0;
        MEM_stall     = 1'b0;

        if (!reset) begin
            if (mem_pend) begin
                PC_stall    = 1'b1;
                IF_ID_stall = 1'b1;
                EX_stall    = 1'b1;
                MEM_stall   = 1'b1;
            end else if (mul_busy) begin
                PC_stall      = 1'b1;
                IF_ID_stall   = 1'b1;
                EX_stall      = 1'b1;
                EX_MEM_bubble = 1'b1;
            end else if (EX_take) begin
                // Redirect wins over a load-use: the younger instructions
                // are being squashed anyway, so the PC must move.
                IF_ID_flush = 1'b1;
                ID_bubble   = 1'b1;
            end else if (load_use) begin
                PC_stall    = 1'b1;
                IF_ID_stall = 1'b1;
                ID_bubble   = 1'b1;
            end
        end
    end

    assign mem_timeout = mem_timeout_reg;

    // ------------------------------------------------------------------
    // Performance counters
    // ------------------------------------------------------------------
    hazard_perf_cnt #(
        .W (PERF_CNT_W)
    ) u_stall_cnt (
        .clk   (clk),
        .reset (reset),
        .en    (PC_stall),
        .count (stall_count)
    );

    hazard_perf_cnt #(
        .W (PERF_CNT_W)
    ) u_flush_cnt (
        .clk   (clk),
        .reset (reset),
        .en    (IF_ID_flush),
        .count (flush_count)
    );

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl: inputs change on the falling edge, outputs
// are sampled 1 ns later or on the following falling edge.
module tb_hazard_ctrl;
    import hazard_ctrl_pkg::*;

    logic        clk;
    logic        reset;
    logic [4:0]  ID_rs1, ID_rs2;
    logic        ID_uses_rs1, ID_uses_rs2;
    logic        ID_EX_memread;
    logic [4:0]  ID_EX_rd;
    logic [3:0]  ID_EX_aluop;
    logic        EX_take;
    logic        EX_MEM_memread, EX_MEM_memwrite, mem_ready;
    logic        PC_stall, IF_ID_stall, IF_ID_flush, ID_bubble;
    logic        EX_stall, EX_MEM_bubble, MEM_stall;
    logic        mem_timeout;
    logic [15:0] stall_count, flush_count;

    // {PC_stall, IF_ID_stall, IF_ID_flush, ID_bubble, EX_stall, EX_MEM_bubble, MEM_stall}
    logic [6:0]  ctl;
    assign ctl = {PC_stall, IF_ID_stall, IF_ID_flush, ID_bubble,
                  EX_stall, EX_MEM_bubble, MEM_stall};

    localparam logic [6:0] C_IDLE = 7'b0000000;
    localparam logic [6:0] C_LU   = 7'b1101000;
    localparam logic [6:0] C_MUL  = 7'b1100110;
    localparam logic [6:0] C_MEM  = 7'b1100101;
    localparam logic [6:0] C_FL   = 7'b0011000;

    int total = 0;
    int bad   = 0;
    int exp_stall = 0;
    int exp_flush = 0;

    hazard_ctrl #(
        .MUL_LAT     (3),
        .MUL_ALUOP   (4'b1010),
        .MEM_TIMEOUT (255)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .ID_rs1          (ID_rs1),
        .ID_rs2          (ID_rs2),
        .ID_uses_rs1     (ID_uses_rs1),
        .ID_uses_rs2     (ID_uses_rs2),
        .ID_EX_memread   (ID_EX_memread),
        .ID_EX_rd        (ID_EX_rd),
        .ID_EX_aluop     (ID_EX_aluop),
        .EX_take         (EX_take),
        .EX_MEM_memread  (EX_MEM_memread),
        .EX_MEM_memwrite (EX_MEM_memwrite),
        .mem_ready       (mem_ready),
        .PC_stall        (PC_stall),
        .IF_ID_stall     (IF_ID_stall),
        .IF_ID_flush     (IF_ID_flush),
        .ID_bubble       (ID_bubble),
        .EX_stall        (EX_stall),
        .EX_MEM_bubble   (EX_MEM_bubble),
        .MEM_stall       (MEM_stall),
        .mem_timeout     (mem_timeout),
        .stall_count     (stall_count),
        .flush_count     (flush_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic idle_inputs();
        ID_rs1 = 5'd0; ID_rs2 = 5'd0; ID_uses_rs1 = 1'b0; ID_uses_rs2 = 1'b0;
        ID_EX_memread = 1'b0; ID_EX_rd = 5'd0; ID_EX_aluop = 4'd0;
        EX_take = 1'b0;
        EX_MEM_memread = 1'b0; EX_MEM_memwrite = 1'b0; mem_ready = 1'b1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        idle_inputs();
        // A load-use pattern while reset is high must not leak through.
        ID_EX_memread = 1'b1; ID_EX_rd = 5'd5; ID_rs2 = 5'd5; ID_uses_rs2 = 1'b1;
        repeat (2) @(negedge clk);
        $display("reset: ctl=%b stall_count=%0d flush_count=%0d timeout=%b",
                 ctl, stall_count, flush_count, mem_timeout);
        total++; if (ctl !== C_IDLE) begin bad++; $display("FAIL reset_ctl got=%b want=%b", ctl, C_IDLE); end
        total++; if (stall_count !== 16'd0) begin bad++; $display("FAIL reset_stall_cnt got=%0d want=0", stall_count); end
        total++; if (flush_count !== 16'd0) begin bad++; $display("FAIL reset_flush_cnt got=%0d want=0", flush_count); end
        total++; if (mem_timeout !== 1'b0) begin bad++; $display("FAIL reset_timeout got=%b want=0", mem_timeout); end
        total++; if (dut.state_reg !== ST_RUN) begin bad++; $display("FAIL reset_state got=%0d want=%0d", dut.state_reg, ST_RUN); end
        idle_inputs();
        reset = 1'b0;
        exp_stall = 0;
        exp_flush = 0;
    endtask

    task automatic test_load_use();
        @(negedge clk);
        ID_EX_memread = 1'b1; ID_EX_rd = 5'd5; ID_rs2 = 5'd5; ID_uses_rs2 = 1'b1;
        #1;
        $display("load_use rs2: ctl=%b", ctl);
        total++; if (ctl !== C_LU) begin bad++; $display("FAIL lu_rs2 got=%b want=%b", ctl, C_LU); end
        exp_stall++;
        @(negedge clk);
        idle_inputs();
        #1;
        $display("load_use release: ctl=%b stall_count=%0d", ctl, stall_count);
        total++; if (ctl !== C_IDLE) begin bad++; $display("FAIL lu_release got=%b want=%b", ctl, C_IDLE); end
        total++; if (stall_count !== 16'(exp_stall)) begin bad++; $display("FAIL lu_stall_cnt got=%0d want=%0d", stall_count, exp_stall); end
        // Matching register but operand not used: no interlock.
        @(negedge clk);
        ID_EX_memread = 1'b1; ID_EX_rd = 5'd5; ID_rs2 = 5'd5; ID_uses_rs2 = 1'b0;
        #1;
        $display("load_use unused: ctl=%b", ctl);
        total++; if (ctl !== C_IDLE) begin bad++; $display("FAIL lu_unused got=%b want=%b", ctl, C_IDLE); end
        // x0 destination never interlocks.
        @(negedge clk);
        idle_inputs();
        ID_EX_memread = 1'b1; ID_EX_rd = 5'd0; ID_rs1 = 5'd0; ID_uses_rs1 = 1'b1;
        #1;
        $display("load_use x0: ctl=%b", ctl);
        total++; if (ctl !== C_IDLE) begin bad++; $display("FAIL lu_x0 got=%b want=%b", ctl, C_IDLE); end
        // Match through rs1.
        @(negedge clk);
        idle_inputs();
        ID_EX_memread = 1'b1; ID_EX_rd = 5'd7; ID_rs1 = 5'd7; ID_uses_rs1 = 1'b1;
        #1;
        $display("load_use rs1: ctl=%b", ctl);
        total++; if (ctl !== C_LU) begin bad++; $display("FAIL lu_rs1 got=%b want=%b", ctl, C_LU); end
        exp_stall++;
        @(negedge clk);
        idle_inputs();
        #1;
        total++; if (stall_count !== 16'(exp_stall)) begin bad++; $display("FAIL lu_stall_cnt2 got=%0d want=%0d", stall_count, exp_stall); end
    endtask

    task automatic test_back_to_back_mul();
        logic [6:0] exp_seq [6];
        exp_seq[0] = C_MUL; exp_seq[1] = C_MUL; exp_seq[2] = C_IDLE;
        exp_seq[3] = C_MUL; exp_seq[4] = C_MUL; exp_seq[5] = C_IDLE;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            ID_EX_aluop = 4'b1010;
            #1;
            $display("mul cycle %0d: ctl=%b", i, ctl);
            total++; if (ctl !== exp_seq[i]) begin bad++; $display("FAIL mul_c%0d got=%b want=%b", i, ctl, exp_seq[i]); end
        end
        exp_stall += 4;
        @(negedge clk);
        idle_inputs();
        #1;
        $display("mul done: ctl=%b stall_count=%0d", ctl, stall_count);
        total++; if (ctl !== C_IDLE) begin bad++; $display("FAIL mul_after got=%b want=%b", ctl, C_IDLE); end
        total++; if (stall_count !== 16'(exp_stall)) begin bad++; $display("FAIL mul_stall_cnt got=%0d want=%0d", stall_count, exp_stall); end
    endtask

    task automatic test_mem_wait();
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            idle_inputs();
            EX_MEM_memread = 1'b1; mem_ready = 1'b0;
            if (i == 2) begin
                // Load-use underneath a memory wait is shadowed.
                ID_EX_memread = 1'b1; ID_EX_rd = 5'd3; ID_rs1 = 5'd3; ID_uses_rs1 = 1'b1;
            end
            #1;
            $display("mem wait %0d: ctl=%b", i, ctl);
            total++; if (ctl !== C_MEM) begin bad++; $display("FAIL mem_wait_%0d got=%b want=%b", i, ctl, C_MEM); end
        end
        exp_stall += 4;
        @(negedge clk);
        idle_inputs();
        EX_MEM_memread = 1'b1; mem_ready = 1'b1;
        #1;
        $display("mem ready: ctl=%b", ctl);
        total++; if (ctl !== C_IDLE) begin bad++; $display("FAIL mem_release got=%b want=%b", ctl, C_IDLE); end
        @(negedge clk);
        idle_inputs();
        #1;
        total++; if (stall_count !== 16'(exp_stall)) begin bad++; $display("FAIL mem_stall_cnt got=%0d want=%0d", stall_count, exp_stall); end
        total++; if (mem_timeout !== 1'b0) begin bad++; $display("FAIL mem_no_timeout got=%b want=0", mem_timeout); end
    endtask

    task automatic test_flush();
        @(negedge clk);
        EX_take = 1'b1;
        ID_EX_memread = 1'b1; ID_EX_rd = 5'd5; ID_rs2 = 5'd5; ID_uses_rs2 = 1'b1;
        #1;
        $display("flush+load_use: ctl=%b", ctl);
        total++; if (ctl !== C_FL) begin bad++; $display("FAIL flush_lu got=%b want=%b", ctl, C_FL); end
        exp_flush++;
        // Memory wait outranks the branch.
        @(negedge clk);
        idle_inputs();
        EX_take = 1'b1; EX_MEM_memwrite = 1'b1; mem_ready = 1'b0;
        #1;
        $display("flush under mem wait: ctl=%b", ctl);
        total++; if (ctl !== C_MEM) begin bad++; $display("FAIL flush_mem got=%b want=%b", ctl, C_MEM); end
        exp_stall++;
        @(negedge clk);
        idle_inputs();
        #1;
        $display("flush counters: flush_count=%0d stall_count=%0d", flush_count, stall_count);
        total++; if (flush_count !== 16'(exp_flush)) begin bad++; $display("FAIL flush_cnt got=%0d want=%0d", flush_count, exp_flush); end
        total++; if (stall_count !== 16'(exp_stall)) begin bad++; $display("FAIL flush_stall_cnt got=%0d want=%0d", stall_count, exp_stall); end
    endtask

    task automatic test_mul_memwait();
        logic [6:0] exp_seq [4];
        exp_seq[0] = C_MUL; exp_seq[1] = C_MEM; exp_seq[2] = C_MUL; exp_seq[3] = C_IDLE;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            idle_inputs();
            ID_EX_aluop = 4'b1010;
            if (i == 1) begin EX_MEM_memread = 1'b1; mem_ready = 1'b0; end
            if (i == 2) begin EX_MEM_memread = 1'b1; mem_ready = 1'b1; end
            #1;
            $display("mul+mem cycle %0d: ctl=%b", i, ctl);
            total++; if (ctl !== exp_seq[i]) begin bad++; $display("FAIL mulmem_c%0d got=%b want=%b", i, ctl, exp_seq[i]); end
        end
        exp_stall += 3;
        @(negedge clk);
        idle_inputs();
        #1;
        total++; if (stall_count !== 16'(exp_stall)) begin bad++; $display("FAIL mulmem_stall_cnt got=%0d want=%0d", stall_count, exp_stall); end
    endtask

    task automatic test_timeout();
        @(negedge clk);
        idle_inputs();
        EX_MEM_memread = 1'b1; mem_ready = 1'b0;
        for (int i = 1; i <= 300; i++) begin
            @(negedge clk);
            if (i == 254) begin
                $display("timeout after %0d wait cycles: %b", i, mem_timeout);
                total++; if (mem_timeout !== 1'b0) begin bad++; $display("FAIL timeout_early got=%b want=0", mem_timeout); end
            end
            if (i == 255) begin
                $display("timeout after %0d wait cycles: %b", i, mem_timeout);
                total++; if (mem_timeout !== 1'b1) begin bad++; $display("FAIL timeout_set got=%b want=1", mem_timeout); end
            end
            if (i == 300) begin
                $display("timeout after %0d wait cycles: %b ctl=%b", i, mem_timeout, ctl);
                total++; if (ctl !== C_MEM) begin bad++; $display("FAIL timeout_ctl got=%b want=%b", ctl, C_MEM); end
            end
        end
        exp_stall += 300;
        idle_inputs();
        @(negedge clk);
        $display("timeout after release: %b stall_count=%0d", mem_timeout, stall_count);
        total++; if (mem_timeout !== 1'b1) begin bad++; $display("FAIL timeout_sticky got=%b want=1", mem_timeout); end
        total++; if (stall_count !== 16'(exp_stall)) begin bad++; $display("FAIL timeout_stall_cnt got=%0d want=%0d", stall_count, exp_stall); end
        reset = 1'b1;
        #1;
        $display("timeout under reset: %b", mem_timeout);
        total++; if (mem_timeout !== 1'b0) begin bad++; $display("FAIL timeout_reset got=%b want=0", mem_timeout); end
        total++; if (stall_count !== 16'd0) begin bad++; $display("FAIL timeout_reset_cnt got=%0d want=0", stall_count); end
        @(negedge clk);
        reset = 1'b0;
        exp_stall = 0;
        exp_flush = 0;
    endtask

    task automatic test_reset_mid_mul();
        @(negedge clk);
        idle_inputs();
        ID_EX_aluop = 4'b1010;
        #1;
        total++; if (ctl !== C_MUL) begin bad++; $display("FAIL rstmul_c0 got=%b want=%b", ctl, C_MUL); end
        @(negedge clk);
        reset = 1'b1;
        #1;
        $display("reset mid-mul: ctl=%b state=%0d cnt=%0d", ctl, dut.state_reg, dut.mul_cnt_reg);
        total++; if (ctl !== C_IDLE) begin bad++; $display("FAIL rstmul_ctl got=%b want=%b", ctl, C_IDLE); end
        total++; if (dut.state_reg !== ST_RUN) begin bad++; $display("FAIL rstmul_state got=%0d want=%0d", dut.state_reg, ST_RUN); end
        total++; if (dut.mul_cnt_reg !== 4'd0) begin bad++; $display("FAIL rstmul_cnt got=%0d want=0", dut.mul_cnt_reg); end
        @(negedge clk);
        reset = 1'b0;
        idle_inputs();
        exp_stall = 0;
        @(negedge clk);
        total++; if (dut.state_reg !== ST_RUN) begin bad++; $display("FAIL rstmul_post_state got=%0d want=%0d", dut.state_reg, ST_RUN); end
        // A fresh multiply gets its full stall budget.
        for (int i = 0; i < 3; i++) begin
            ID_EX_aluop = 4'b1010;
            #1;
            $display("post-reset mul cycle %0d: ctl=%b", i, ctl);
            total++; if (ctl !== ((i < 2) ? C_MUL : C_IDLE)) begin bad++; $display("FAIL rstmul_new_c%0d got=%b want=%b", i, ctl, (i < 2) ? C_MUL : C_IDLE); end
            @(negedge clk);
        end
        exp_stall += 2;
        idle_inputs();
        #1;
        total++; if (stall_count !== 16'(exp_stall)) begin bad++; $display("FAIL rstmul_stall_cnt got=%0d want=%0d", stall_count, exp_stall); end
        // Reset abandons a memory wait too.
        @(negedge clk);
        EX_MEM_memread = 1'b1; mem_ready = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        idle_inputs();
        @(negedge clk);
        reset = 1'b0;
        #1;
        $display("reset mid-memwait: state=%0d ctl=%b", dut.state_reg, ctl);
        total++; if (dut.state_reg !== ST_RUN) begin bad++; $display("FAIL rstmem_state got=%0d want=%0d", dut.state_reg, ST_RUN); end
        total++; if (ctl !== C_IDLE) begin bad++; $display("FAIL rstmem_ctl got=%b want=%b", ctl, C_IDLE); end
    endtask

    initial begin
        idle_inputs();
        reset = 1'b1;
        test_reset();
        test_load_use();
        test_back_to_back_mul();
        test_mem_wait();
        test_flush();
        test_mul_memwait();
        test_timeout();
        test_reset_mid_mul();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
